// File: rtl/tap_encoder.sv
// tap_encoder: transmit side of the JTAG USER data register. Buffers result words in a FIFO and
// shifts one {word, presence} frame per DR scan, LSB first. Option: TAP_ENCODER_FULL_FRAME_EN.
module tap_encoder #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  tck,
   input  logic                  test_logic_reset,
   input  logic                  ir_is_user,
   input  logic                  capture_dr,
   input  logic                  shift_dr,
   input  logic                  update_dr,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  tdo
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int FRAME_W = DATA_WIDTH + 1;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ARMED = 1'b1;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic [FRAME_W-1:0]    sr;
   logic [0:0]            state;

   logic do_capture;
   logic do_shift;
   logic do_update;
   logic push;
   logic pop;
   logic pop_ok;
   logic fifo_empty;

   assign do_capture = ir_is_user && capture_dr;
   assign do_shift   = ir_is_user && shift_dr;
   assign do_update  = ir_is_user && update_dr;

   assign in_ready   = (count != CNT_FULL);
   assign fifo_empty = (count == '0);
   assign push       = in_valid && in_ready;
   assign pop        = do_update && (state == ST_ARMED) && pop_ok;
   assign tdo        = sr[0];

`ifdef TAP_ENCODER_FULL_FRAME_EN
   localparam int BC_W = $clog2(FRAME_W + 1);
   localparam logic [BC_W-1:0] BC_FULL = BC_W'(FRAME_W);

   // Counts shift edges since capture; a word is consumed only once the whole frame went out.
   logic [BC_W-1:0] bit_cnt;

   always_ff @(posedge tck or posedge test_logic_reset) begin
      if (test_logic_reset) begin
         bit_cnt <= '0;
      end else if (do_capture && !fifo_empty) begin
         bit_cnt <= '0;
      end else if (do_shift && (bit_cnt != BC_FULL)) begin
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

   assign pop_ok = (bit_cnt == BC_FULL);
`else
   assign pop_ok = 1'b1;
`endif

   // Storage is data only; occupancy and pointers define what is valid.
   always_ff @(posedge tck) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge tck or posedge test_logic_reset) begin
      if (test_logic_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   // Capture snapshots the head without consuming it; only update commits the pop.
   always_ff @(posedge tck or posedge test_logic_reset) begin
      if (test_logic_reset) begin
         sr    <= '0;
         state <= ST_IDLE;
      end else if (do_capture) begin
         if (!fifo_empty) begin
            sr    <= {mem[rd_ptr], 1'b1};
            state <= ST_ARMED;
         end else begin
            sr    <= '0;
            state <= ST_IDLE;
         end
      end else if (do_shift) begin
         sr <= {1'b0, sr[FRAME_W-1:1]};
      end else if (do_update) begin
         state <= ST_IDLE;
      end
   end

endmodule

// File: doc/tap_encoder.md
# tap_encoder

Transmit side of the JTAG user data register. Accepts result words from the solver core through a valid/ready handshake, buffers them in a small FIFO, and presents one word per DR scan on `tdo`, LSB first. Each frame carries a leading presence flag, so the host can tell a real result from an empty scan. The block sits next to `tap_decoder` on the same TAP signals, in the `tck` domain.

## Interface
- `DATA_WIDTH`, 16: result word width; a frame is `DATA_WIDTH+1` bits.
- `FIFO_DEPTH`, 4: buffered words; power of two, at least 2.

- `tck`  in  1  TAP clock; all logic on its rising edge.
- `test_logic_reset`  in  1  asynchronous, active-high reset.
- `ir_is_user`  in  1  USER instruction selected.
- `capture_dr`  in  1  TAP in Capture-DR.
- `shift_dr`  in  1  TAP in Shift-DR.
- `update_dr`  in  1  TAP in Update-DR.
- `in_data`  in  DATA_WIDTH  result word from the core.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO can accept a word.
- `tdo`  out  1  serial output; equals shift register bit 0.

## Operation
- **FIFO**
  - `FIFO_DEPTH` entries with a `$clog2(FIFO_DEPTH)+1` bit occupancy count.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
  - A push happens when `in_valid && in_ready`.
  - `in_ready = (count != FIFO_DEPTH)`, combinational from the count.
- **Frame**
  - Shift register `sr` is `DATA_WIDTH+1` bits: `sr[0]` is the presence flag, `sr[DATA_WIDTH:1]` is the word.
  - `tdo = sr[0]`.
- **FSM states**
  - IDLE: no entry committed to a scan.
  - ARMED: FIFO head loaded into `sr`, awaiting update.
- **Capture** (`ir_is_user && capture_dr`, any state)
  - FIFO non-empty: `sr <= {head, 1'b1}`, `bit_cnt <= 0`, go to ARMED.
  - FIFO empty: `sr <= '0`, go to IDLE.
- **Shift** (`ir_is_user && shift_dr`)
  - `sr <= {1'b0, sr[DATA_WIDTH:1]}`.
  - `bit_cnt` increments and saturates at `DATA_WIDTH+1`.
- **Update** (`ir_is_user && update_dr`)
  - In ARMED, pop the head when the pop condition holds (see Configuration); always return to IDLE.
  - In IDLE, no effect.
- **Simultaneous events**
  - Push and pop in the same cycle: count unchanged, pointers both advance.
  - Push into a full FIFO cannot occur, because `in_ready` is 0.
  - A push in the capture cycle into an empty FIFO is not captured; that scan reads presence 0.
- **Other rules**
  - Control inputs with `ir_is_user` low are ignored; `sr` and the FSM hold.
  - Capture, shift and update are mutually exclusive by TAP construction; no priority is defined among them.
  - `test_logic_reset` mid-scan or mid-push clears the FIFO. Buffered words are lost by design.

## Timing
- Reset values:
  - `sr = 0`, so `tdo = 0`.
  - `count = 0`, so `in_ready = 1`.
  - Pointers 0, `bit_cnt` 0, FSM in IDLE.
- A pushed word is capturable from the cycle after the push.
- `tdo` shows the presence flag in the cycle after capture; each shift edge exposes the next bit.
- Word bit `k` appears after `k+1` shift edges.
- The pop takes effect on the update edge. `in_ready` rises in the next cycle if the FIFO was full.

## Configuration
- `TAP_ENCODER_FULL_FRAME_EN` defined:
  - Pop only if `bit_cnt == DATA_WIDTH+1` at update.
  - A truncated scan leaves the word at the head, and the next scan re-reads it.
- Undefined:
  - Pop on any update in ARMED, regardless of `bit_cnt`.

## Test plan
- **Reset and empty scan:** reset, then capture, 17 shifts, update → `tdo` reads 0 for all 17 bits; `in_ready = 1`; count stays 0.
- **Single word:** push `0xA5C3`, then scan 17 bits → `tdo` sequence is 1, then `0xA5C3` LSB first; count returns to 0 after update.
- **Full and back-pressure:** push 4 words with `in_valid` held high → `in_ready` is 0 after the 4th push; a 5th word held on `in_data` is accepted the cycle after the first pop.
- **Truncated scan:** push `0x1234`, scan only 5 bits, update, then run a full scan.
  - With `TAP_ENCODER_FULL_FRAME_EN`: the full scan returns `0x1234`.
  - Without it: the full scan returns presence 0.
- **Concurrent push and pop:** with 2 words queued, push `0xBEEF` in the update cycle → count stays 2; three full scans return the words in order, `0xBEEF` last.
- **Reset mid-shift:** assert `test_logic_reset` after 8 shift bits → `tdo = 0`, `in_ready = 1`, FSM in IDLE, FIFO empty.
